// File: rtl/im_loader_pkg.sv
// Shared constants and loader state encoding, used by the loader, the instruction memory
// and the CPU top.
package im_loader_pkg;

    localparam int unsigned IMSIZE = 8;
    localparam int unsigned IM_MAX = 256;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StVerify,
        StErr
    } ld_state_e;

endpackage

// File: rtl/im_loader_if.sv
// Host-to-loader word stream: valid/data from the host, ready back from the loader.
interface im_loader_if;
    import im_loader_pkg::*;

    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: streams a host program into IM while stalling the CPU, then
// reads it back and checks both XOR checksums before handing IM back to the CPU.
module im_loader #(
    parameter int unsigned IMSIZE = im_loader_pkg::IMSIZE,
    parameter int unsigned IM_MAX = im_loader_pkg::IM_MAX
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_start,
    input  logic [IMSIZE:0]                  load_len,
    input  logic [im_loader_pkg::WORD_W-1:0] load_csum,
    im_loader_if.slave                       host,
    input  logic [IMSIZE-1:0]                cpu_pc,
    output logic                             cpu_stall,
    output logic                             im_wea,
    output logic [IMSIZE-1:0]                im_addr,
    output logic [im_loader_pkg::WORD_W-1:0] im_din,
    input  logic [im_loader_pkg::WORD_W-1:0] im_dout,
    output logic                             load_done,
    output logic                             load_err,
    input  logic                             err_clr
);
    import im_loader_pkg::*;

    localparam logic [IMSIZE:0]   MaxLen   = (IMSIZE + 1)'(IM_MAX);
    localparam logic [IMSIZE-1:0] LastAddr = IMSIZE'(IM_MAX - 1);

    ld_state_e         state_q, state_d;
    logic [IMSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [IMSIZE:0]   rd_ptr_q, rd_ptr_d;
    logic [IMSIZE:0]   len_q, len_d;
    logic [WORD_W-1:0] csum_q, csum_d;
    logic [WORD_W-1:0] acc_wr_q, acc_wr_d;
    logic [WORD_W-1:0] acc_rd_q, acc_rd_d;
    logic              done_q, done_d;
    logic              bad_len_q, bad_len_d;

    logic              len_ok;
    logic              last_wr;
    logic              rd_last;
    logic [WORD_W-1:0] rd_final;

    assign len_ok   = (load_len != '0) && (load_len <= MaxLen);
    assign last_wr  = ({1'b0, wr_ptr_q} == (len_q - 1'b1));
    assign rd_last  = (rd_ptr_q == len_q);
    // Readback data lags the address by one cycle, so the last word arrives with rd_ptr == len.
    assign rd_final = acc_rd_q ^ im_dout;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        csum_d       = csum_q;
        acc_wr_d     = acc_wr_q;
        acc_rd_d     = acc_rd_q;
        done_d       = 1'b0;
        bad_len_d    = 1'b0;
        host.s_ready = 1'b0;
        cpu_stall    = 1'b1;
        im_wea       = 1'b0;
        im_addr      = cpu_pc;
        im_din       = host.s_data;

        unique case (state_q)
            StRun: begin
                cpu_stall = 1'b0;
                if (load_start) begin
                    if (len_ok) begin
                        len_d    = load_len;
                        csum_d   = load_csum;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        acc_wr_d = '0;
                        acc_rd_d = '0;
                        state_d  = StLoad;
                    end else begin
                        bad_len_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                host.s_ready = 1'b1;
                im_addr      = wr_ptr_q;
                if (host.s_valid) begin
                    im_wea   = 1'b1;
                    acc_wr_d = acc_wr_q ^ host.s_data;
                    wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
                    if (last_wr) begin
                        state_d = StVerify;
                    end
                end
            end
            StVerify: begin
                im_addr = rd_ptr_q[IMSIZE-1:0];
                if (rd_ptr_q != '0) begin
                    acc_rd_d = rd_final;
                end
                if (rd_last) begin
                    if ((acc_wr_q == csum_q) && (rd_final == csum_q)) begin
                        done_d  = 1'b1;
                        state_d = StRun;
                    end else begin
                        state_d = StErr;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            StErr: begin
                if (err_clr) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            len_q     <= '0;
            csum_q    <= '0;
            acc_wr_q  <= '0;
            acc_rd_q  <= '0;
            done_q    <= 1'b0;
            bad_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            len_q     <= len_d;
            csum_q    <= csum_d;
            acc_wr_q  <= acc_wr_d;
            acc_rd_q  <= acc_rd_d;
            done_q    <= done_d;
            bad_len_q <= bad_len_d;
        end
    end

    assign load_done = done_q;
    assign load_err  = (state_q == StErr) || bad_len_q;

endmodule

// File: tb/tb_im_loader.sv
// Randomized bench for im_loader: a behavioural IM plus a per-load expectation of writes,
// verify sweep and checksum outcome.
module tb_im_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [8:0]  load_len;
    logic [31:0] load_csum;
    logic [7:0]  cpu_pc;
    logic        cpu_stall;
    logic        im_wea;
    logic [7:0]  im_addr;
    logic [31:0] im_din;
    logic [31:0] im_dout;
    logic        load_done;
    logic        load_err;
    logic        err_clr;

    im_loader_if host_if ();

    im_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_len   (load_len),
        .load_csum  (load_csum),
        .host       (host_if.slave),
        .cpu_pc     (cpu_pc),
        .cpu_stall  (cpu_stall),
        .im_wea     (im_wea),
        .im_addr    (im_addr),
        .im_din     (im_din),
        .im_dout    (im_dout),
        .load_done  (load_done),
        .load_err   (load_err),
        .err_clr    (err_clr)
    );

    logic [31:0] mem [256];
    logic [31:0] words [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory: data valid one cycle after the address.
    always @(posedge clk) begin
        im_dout <= mem[im_addr];
        if (im_wea) begin
            mem[im_addr] <= im_din;
            wr_count     <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: s_valid every cycle, 1: every other cycle, 2: random with stray load_start
    task automatic run_load(input int len, input logic [31:0] csum, input int mode);
        logic [31:0] x;
        bit          ok;
        bit          v;
        int          idx;
        int          cyc;
        int          wr0;
        int          bad;
        x = '0;
        for (int i = 0; i < len; i++) x ^= words[i];
        ok  = (x == csum);
        wr0 = wr_count;

        @(negedge clk);
        load_start      = 1'b1;
        load_len        = 9'(len);
        load_csum       = csum;
        host_if.s_valid = 1'b0;
        #1;
        check("start_stall", cpu_stall, 0);
        check("start_ready", host_if.s_ready, 0);

        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 4 * len + 16) begin
            @(negedge clk);
            load_start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            host_if.s_valid = v;
            host_if.s_data  = words[idx];
            #1;
            check("load_ready", host_if.s_ready, 1);
            check("load_stall", cpu_stall, 1);
            check("load_wea", im_wea, 32'(v));
            if (v) begin
                check("load_addr", im_addr, 32'(idx % 256));
                check("load_din", im_din, words[idx]);
                idx++;
            end
            cyc++;
        end
        if (idx < len) begin
            check("load_timeout", idx, len);
            return;
        end

        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            load_start      = 1'b0;
            host_if.s_valid = 1'($urandom_range(0, 1));
            #1;
            check("ver_ready", host_if.s_ready, 0);
            check("ver_wea", im_wea, 0);
            check("ver_stall", cpu_stall, 1);
            check("ver_done", load_done, 0);
            if (k < len) check("ver_addr", im_addr, 32'(k));
        end

        @(negedge clk);
        host_if.s_valid = 1'b0;
        cpu_pc          = 8'($urandom);
        #1;
        check("wr_count", wr_count - wr0, len);
        bad = 0;
        for (int i = 0; i < len; i++) if (mem[i] !== words[i]) bad++;
        check("mem_content", bad, 0);
        if (ok) begin
            check("end_done", load_done, 1);
            check("end_stall", cpu_stall, 0);
            check("end_err", load_err, 0);
            check("end_pc_addr", im_addr, 32'(cpu_pc));
            @(negedge clk);
            #1;
            check("done_pulse", load_done, 0);
        end else begin
            check("end_err", load_err, 1);
            check("end_stall", cpu_stall, 1);
            check("end_done", load_done, 0);
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                load_start = 1'b1;
                load_len   = 9'd4;
                #1;
                check("err_hold", load_err, 1);
                check("err_ready", host_if.s_ready, 0);
            end
            @(negedge clk);
            err_clr    = 1'b1;
            load_start = 1'b1;
            #1;
            check("err_clr_cycle", load_err, 1);
            @(negedge clk);
            err_clr    = 1'b0;
            load_start = 1'b0;
            #1;
            check("clr_err", load_err, 0);
            check("clr_stall", cpu_stall, 0);
            check("clr_ready", host_if.s_ready, 0);
        end
    endtask

    task automatic bad_len(input logic [8:0] len);
        int wr0;
        wr0 = wr_count;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len;
        #1;
        check("badlen_stall", cpu_stall, 0);
        @(negedge clk);
        load_start = 1'b0;
        #1;
        check("badlen_pulse", load_err, 1);
        check("badlen_ready", host_if.s_ready, 0);
        check("badlen_stay", cpu_stall, 0);
        @(negedge clk);
        #1;
        check("badlen_pulse_end", load_err, 0);
        check("badlen_no_wr", wr_count - wr0, 0);
    endtask

    initial begin
        logic [31:0] x;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n           = 1'b0;
        load_start      = 1'b0;
        load_len        = '0;
        load_csum       = '0;
        cpu_pc          = 8'd0;
        err_clr         = 1'b0;
        host_if.s_valid = 1'b0;
        host_if.s_data  = '0;
        #12;
        check("rst_stall", cpu_stall, 0);
        check("rst_ready", host_if.s_ready, 0);
        check("rst_wea", im_wea, 0);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // RUN: CPU owns the address, host stream is refused.
        @(negedge clk);
        cpu_pc          = 8'd7;
        host_if.s_valid = 1'b1;
        #1;
        check("run_addr", im_addr, 7);
        check("run_wea", im_wea, 0);
        check("run_ready", host_if.s_ready, 0);
        @(negedge clk);
        host_if.s_valid = 1'b0;

        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h4; words[3] = 32'h8;
        run_load(4, 32'h0000_000F, 0);

        words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
        run_load(3, 32'hDEAD_BEEF, 0);

        bad_len(9'd0);
        bad_len(9'd257);

        x = '0;
        for (int i = 0; i < 256; i++) begin
            words[i] = $urandom;
            x ^= words[i];
        end
        run_load(256, x, 1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 24);
            x = '0;
            for (int i = 0; i < n; i++) begin
                words[i] = $urandom;
                x ^= words[i];
            end
            if ($urandom_range(0, 1) == 1) x ^= 32'h1 << $urandom_range(0, 31);
            run_load(n, x, 2);
        end

        // Reset in the middle of a load.
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 9'd5;
        load_csum  = 32'h0;
        #1;
        check("mid_start_stall", cpu_stall, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            load_start      = 1'b0;
            host_if.s_valid = 1'b1;
            host_if.s_data  = words[i];
            #1;
            check("mid_addr", im_addr, 32'(i));
        end
        @(negedge clk);
        rst_n  = 1'b0;
        cpu_pc = 8'h21;
        #1;
        check("mid_rst_stall", cpu_stall, 0);
        check("mid_rst_ready", host_if.s_ready, 0);
        check("mid_rst_wea", im_wea, 0);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_err", load_err, 0);
        check("mid_rst_addr", im_addr, 32'h21);
        @(negedge clk);
        rst_n  = 1'b1;
        cpu_pc = 8'h33;
        #1;
        check("post_rst_addr", im_addr, 32'h33);
        check("post_rst_ready", host_if.s_ready, 0);
        @(negedge clk);
        host_if.s_valid = 1'b0;
        cpu_pc          = 8'h34;
        #1;
        check("post_rst_addr2", im_addr, 32'h34);
        check("post_rst_stall", cpu_stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter IMSIZE, default 8, is the instruction-memory address width.
REQ-002 Parameter IM_MAX, default 256, is the instruction-memory depth in words.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port load_start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 Port load_len, input, IMSIZE+1 bits: number of words to load; legal range 1..IM_MAX.
REQ-007 Port load_csum, input, 32 bits: expected XOR of all loaded words.
REQ-008 Port s_valid, input, 1 bit: the host word on s_data is valid.
REQ-009 Port s_data, input, 32 bits: host program word.
REQ-010 Port s_ready, output, 1 bit: the loader accepts a host word this cycle.
REQ-011 Port cpu_pc, input, IMSIZE bits: CPU fetch address.
REQ-012 Port cpu_stall, output, 1 bit: freezes CPU fetch and PC.
REQ-013 Port im_wea, output, 1 bit: write enable to the instruction memory.
REQ-014 Port im_addr, output, IMSIZE bits: address to the instruction memory.
REQ-015 Port im_din, output, 32 bits: write data to the instruction memory.
REQ-016 Port im_dout, input, 32 bits: instruction-memory read data, valid one cycle after im_addr.
REQ-017 Port load_done, output, 1 bit: one-cycle pulse when verification passes.
REQ-018 Port load_err, output, 1 bit: level while in state ERR; also a one-cycle pulse on an illegal load_len.
REQ-019 Port err_clr, input, 1 bit: leaves state ERR.

Function
REQ-020 The FSM SHALL have exactly four states: RUN, LOAD, VERIFY and ERR.
REQ-021 In RUN: im_addr = cpu_pc combinationally, im_wea = 0, cpu_stall = 0, s_ready = 0.
REQ-022 RUN with load_start and legal load_len: SHALL latch len and csum, clear wr_ptr and the accumulator, and enter LOAD next cycle.
REQ-023 RUN with load_start and load_len = 0 or > IM_MAX: SHALL stay in RUN and pulse load_err for one cycle.
REQ-024 In LOAD, VERIFY and ERR, cpu_stall SHALL be 1, and load_start SHALL be ignored.
REQ-025 In LOAD: s_ready = 1; on s_valid & s_ready, im_wea = 1, im_addr = wr_ptr, im_din = s_data in the same cycle, wr_ptr increments, and acc ^= s_data.
REQ-026 Write pointer wrap: after writing address IM_MAX-1, the pointer SHALL wrap to 0; a 256-word load ends exactly at the wrap.
REQ-027 When the len-th word is accepted, the FSM SHALL enter VERIFY next cycle, and s_ready SHALL drop in that next cycle.
REQ-028 In VERIFY: im_addr steps through 0..len-1, one address per cycle; im_dout is captured one cycle later into a second XOR accumulator; total duration is len+1 cycles.
REQ-029 At the end of VERIFY, if the write XOR = readback XOR = load_csum: pulse load_done and enter RUN, with cpu_pc controlling im_addr from the next cycle.
REQ-030 At the end of VERIFY, on any mismatch: enter ERR, with load_err = 1 and cpu_stall = 1.
REQ-031 In ERR: err_clr SHALL return the FSM to RUN.
REQ-032 ERR with err_clr and load_start in the same cycle: err_clr SHALL win, and load_start SHALL be ignored.
REQ-033 LOAD with s_valid held low: SHALL wait indefinitely with no timeout and no writes.

Reset
REQ-034 rst_n low SHALL set, asynchronously: state RUN, wr_ptr/rd_ptr 0, both accumulators 0, latched len/csum 0, load_done 0, load_err 0, s_ready 0, cpu_stall 0, im_wea 0.
REQ-035 Reset during LOAD or VERIFY SHALL abandon the load; partially written memory contents are not restored.

Structure
REQ-036 IMSIZE, IM_MAX and the state encoding SHALL live in the shared package, also used by the instruction memory and the CPU top.
REQ-037 No sub-module; the XOR accumulators and pointers are inline.

Verification
REQ-038 load_start, len=4, csum=0x0000_000F; stream 0x1,0x2,0x4,0x8, one per cycle -> the four writes land at addresses 0-3, then VERIFY lasts 5 cycles, load_done pulses once, and cpu_stall drops.
REQ-039 len=3, csum=0xDEAD_BEEF for words 0x1,0x2,0x3 -> enter ERR with cpu_stall=1; err_clr -> RUN.
REQ-040 load_len=0 and load_len=257 -> single-cycle load_err pulse, no state change, im_wea never asserted.
REQ-041 len=256 with s_valid toggling every other cycle -> exactly 256 writes, the last at address 255, pointer wraps to 0, VERIFY reads 0..255.
REQ-042 Assert rst_n low after the 2nd word of a len=5 load -> all outputs at reset values immediately; after release, cpu_pc drives im_addr.
REQ-043 In RUN with cpu_pc=7 -> im_addr=7, im_wea=0; a host s_valid pulse -> s_ready stays 0.
